// File: rtl/shift_reg_pkg.sv
// Shared constants for the serial link: default word length and bit-order selectors,
// used by the transmitter, this receiver and their testers.
package shift_reg_pkg;
    localparam int DEFAULT_WIDTH    = 8;
    localparam int ORDER_MSB_FIRST  = 1;
    localparam int ORDER_LSB_FIRST  = 0;
endpackage

// File: rtl/shift_reg_rx_if.sv
// Serial-side and consumer-side signals of the serial-in / parallel-out receiver.
interface shift_reg_rx_if
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();
    localparam int CW = $clog2(WIDTH);

    logic          shift;
    logic          sin;
    logic          sync;
    logic          rd;
    logic          clrOvr;
    logic [WIDTH-1:0] dataOut;
    logic          valid;
    logic          overrun;
    logic [CW-1:0] bitCnt;

    // Handshake: a word is transferred on any rising edge where valid=1 and rd=1;
    // rd while valid=0 is ignored, and valid never drops without that transfer.
    modport master (
        output shift, sin, sync, rd, clrOvr,
        input  dataOut, valid, overrun, bitCnt
    );

    modport slave (
        input  shift, sin, sync, rd, clrOvr,
        output dataOut, valid, overrun, bitCnt
    );
endinterface

// File: rtl/shift_reg_rx_cnt.sv
// Modulo-WIDTH bit counter: clears on clr, advances on en, pulses wrap on the last bit.
module shift_reg_rx_cnt
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          wrap
);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (at_last) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/shift_reg_rx.sv
// Serial-in, parallel-out receiver: assembles WIDTH-bit words from sin and hands them
// to the consumer through a single holding register with sticky overrun.
module shift_reg_rx
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic           clk,
    input  logic           reset_L,
    shift_reg_rx_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic             ovr_q,   ovr_d;
    logic [CW-1:0]    cnt;
    logic             wrap;
    logic [WIDTH-1:0] assembled;

    shift_reg_rx_cnt #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk     (clk),
        .reset_L (reset_L),
        .clr     (bus.sync),
        .en      (bus.shift),
        .cnt     (cnt),
        .wrap    (wrap)
    );

    // The completed word includes the bit sampled on the completing edge.
    assign assembled = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], bus.sin}
                                        : {bus.sin, shreg_q[WIDTH-1:1]};

    always_comb begin
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (bus.sync) begin
            shreg_d = '0;
        end else if (bus.shift) begin
            shreg_d = wrap ? '0 : assembled;
        end

        if (valid_q && bus.rd) valid_d = 1'b0;
        if (bus.clrOvr)        ovr_d   = 1'b0;

        // A new word always wins; it only counts as overrun if the old one was not taken.
        if (wrap) begin
            data_d  = assembled;
            valid_d = 1'b1;
            if (valid_q && !bus.rd) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.dataOut = data_q;
    assign bus.valid   = valid_q;
    assign bus.overrun = ovr_q;
    assign bus.bitCnt  = cnt;
endmodule

// File: tb/tb_shift_reg_rx.sv
// Directed bench for shift_reg_rx: MSB-first and LSB-first receivers plus a
// transmitter model wired back-to-back into the MSB-first receiver.
module tb_shift_reg_rx;
    import shift_reg_pkg::*;

    logic clk;
    logic reset_L;

    logic shift_m, sin_m, sync_m, rd_m, clr_m;
    logic shift_l, sin_l, sync_l, rd_l, clr_l;
    logic carga, bb;
    logic [7:0] load_v;
    logic [7:0] tx_q;

    int n_tests;
    int n_fail;

    shift_reg_rx_if #(.WIDTH(8)) bus_m ();
    shift_reg_rx_if #(.WIDTH(8)) bus_l ();

    assign bus_m.shift  = shift_m;
    assign bus_m.sin    = bb ? tx_q[7] : sin_m;
    assign bus_m.sync   = sync_m | carga;
    assign bus_m.rd     = rd_m;
    assign bus_m.clrOvr = clr_m;

    assign bus_l.shift  = shift_l;
    assign bus_l.sin    = sin_l;
    assign bus_l.sync   = sync_l;
    assign bus_l.rd     = rd_l;
    assign bus_l.clrOvr = clr_l;

    shift_reg_rx #(.WIDTH(8), .MSB_FIRST(ORDER_MSB_FIRST)) dut_m (
        .clk (clk), .reset_L (reset_L), .bus (bus_m)
    );

    shift_reg_rx #(.WIDTH(8), .MSB_FIRST(ORDER_LSB_FIRST)) dut_l (
        .clk (clk), .reset_L (reset_L), .bus (bus_l)
    );

    // Parallel-load / serial-out transmitter, MSB out first.
    always_ff @(posedge clk) begin
        if (carga)        tx_q <= load_v;
        else if (shift_m) tx_q <= {tx_q[6:0], 1'b0};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        shift_m = 1'b1;
        sin_m   = b;
        tick();
        shift_m = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic rd_last, input logic clr_last);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                rd_m  = rd_last;
                clr_m = clr_last;
            end
            send_bit(w[i]);
        end
        rd_m  = 1'b0;
        clr_m = 1'b0;
    endtask

    task automatic pulse_rd();
        rd_m = 1'b1;
        tick();
        rd_m = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        shift_m = 0; sin_m = 0; sync_m = 0; rd_m = 0; clr_m = 0;
        shift_l = 0; sin_l = 0; sync_l = 0; rd_l = 0; clr_l = 0;
        carga = 0; bb = 0; load_v = 8'h00;
        reset_L = 1'b0;
        repeat (3) tick();

        chk("rst_data",  bus_m.dataOut, 8'h00);
        chk("rst_valid", bus_m.valid,   1'b0);
        chk("rst_ovr",   bus_m.overrun, 1'b0);
        chk("rst_cnt",   bus_m.bitCnt,  3'd0);
        reset_L = 1'b1;
        tick();

        // 1: single word then read
        send_bit(1); send_bit(0); send_bit(1);
        chk("t1_mid_cnt", bus_m.bitCnt, 3'd3);
        send_bit(0); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
        chk("t1_data",  bus_m.dataOut, 8'hA5);
        chk("t1_valid", bus_m.valid,   1'b1);
        chk("t1_cnt",   bus_m.bitCnt,  3'd0);
        chk("t1_ovr",   bus_m.overrun, 1'b0);
        pulse_rd();
        chk("t1_rd_valid", bus_m.valid,   1'b0);
        chk("t1_rd_data",  bus_m.dataOut, 8'hA5);

        // 2: overrun and clear
        send_word(8'h3C, 1'b0, 1'b0);
        chk("t2_first_ovr", bus_m.overrun, 1'b0);
        send_word(8'hC3, 1'b0, 1'b0);
        chk("t2_data",  bus_m.dataOut, 8'hC3);
        chk("t2_valid", bus_m.valid,   1'b1);
        chk("t2_ovr",   bus_m.overrun, 1'b1);
        clr_m = 1'b1; tick(); clr_m = 1'b0;
        chk("t2_clr_ovr",   bus_m.overrun, 1'b0);
        chk("t2_clr_valid", bus_m.valid,   1'b1);

        // 3: read on the completing edge; then clear and overrun together
        pulse_rd();
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b1, 1'b0);
        chk("t3_data",  bus_m.dataOut, 8'h22);
        chk("t3_valid", bus_m.valid,   1'b1);
        chk("t3_ovr",   bus_m.overrun, 1'b0);
        send_word(8'h44, 1'b0, 1'b1);
        chk("t3_setwins_ovr",  bus_m.overrun, 1'b1);
        chk("t3_setwins_data", bus_m.dataOut, 8'h44);
        clr_m = 1'b1; tick(); clr_m = 1'b0;
        chk("t3_ovr_cleared", bus_m.overrun, 1'b0);
        pulse_rd();
        chk("t3_valid_cleared", bus_m.valid, 1'b0);

        // 4: sync discards partial word and masks a simultaneous shift
        send_bit(1); send_bit(1); send_bit(1);
        chk("t4_partial_cnt", bus_m.bitCnt, 3'd3);
        sync_m = 1'b1; shift_m = 1'b1; sin_m = 1'b1;
        tick();
        sync_m = 1'b0; shift_m = 1'b0;
        chk("t4_sync_cnt",   bus_m.bitCnt, 3'd0);
        chk("t4_sync_valid", bus_m.valid,  1'b0);
        send_word(8'h0F, 1'b0, 1'b0);
        chk("t4_data",  bus_m.dataOut, 8'h0F);
        chk("t4_valid", bus_m.valid,   1'b1);
        chk("t4_ovr",   bus_m.overrun, 1'b0);

        // 5: gaps between bits, then asynchronous reset mid-word
        send_bit(1); send_bit(0);
        repeat (4) tick();
        chk("t5_gap_cnt", bus_m.bitCnt, 3'd2);
        send_bit(1); send_bit(1); send_bit(0);
        chk("t5_cnt5", bus_m.bitCnt, 3'd5);
        #3 reset_L = 1'b0;
        #1;
        chk("t5_arst_data",  bus_m.dataOut, 8'h00);
        chk("t5_arst_valid", bus_m.valid,   1'b0);
        chk("t5_arst_cnt",   bus_m.bitCnt,  3'd0);
        chk("t5_arst_ovr",   bus_m.overrun, 1'b0);
        tick();
        reset_L = 1'b1;
        tick();
        send_word(8'h5A, 1'b0, 1'b0);
        chk("t5_data",  bus_m.dataOut, 8'h5A);
        chk("t5_valid", bus_m.valid,   1'b1);
        chk("t5_ovr",   bus_m.overrun, 1'b0);

        // 6a: LSB-first receiver, first bit lands in bit 0
        for (int i = 0; i < 8; i++) begin
            shift_l = 1'b1;
            sin_l   = (i == 0);
            tick();
        end
        shift_l = 1'b0;
        chk("t6_lsb_data",  bus_l.dataOut, 8'h01);
        chk("t6_lsb_valid", bus_l.valid,   1'b1);
        chk("t6_lsb_cnt",   bus_l.bitCnt,  3'd0);

        // 6b: transmitter sout wired to receiver sin
        pulse_rd();
        bb     = 1'b1;
        load_v = 8'h96;
        carga  = 1'b1;
        tick();
        carga  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            shift_m = 1'b1;
            tick();
        end
        shift_m = 1'b0;
        bb      = 1'b0;
        chk("t6_b2b_data",  bus_m.dataOut, 8'h96);
        chk("t6_b2b_valid", bus_m.valid,   1'b1);
        chk("t6_b2b_ovr",   bus_m.overrun, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_reg_rx.md
Name: shift_reg_rx

Overview:
Serial-in, parallel-out receiver. It is the far end of the team's parallel-load / serial-out shift register, the `carga`/`shift`/`sout` transmitter. It samples `sin` on each enabled `shift` cycle and reassembles WIDTH-bit words. Each completed word goes into a holding register with a valid/read handshake and sticky overrun detection. It sits between the serial link and the parallel consumer logic.

Parameters:
- WIDTH, 8, word length in bits; must match the transmitter's `cargaData` width; minimum 2.
- MSB_FIRST, 1, 1 = first received bit lands in dataOut[WIDTH-1]; 0 = first bit lands in dataOut[0].
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk, input, 1, rising-edge clock shared with the transmitter.
- reset_L, input, 1, asynchronous active-low reset.
- shift, input, 1, qualifies `sin` for sampling this cycle (mirrors the transmitter `shift`).
- sin, input, 1, serial data (transmitter `sout`).
- sync, input, 1, word-alignment strobe (mirrors the transmitter `carga`); discards any partial word.
- rd, input, 1, consumer accepts the held word.
- clrOvr, input, 1, clears the overrun flag.
- dataOut, output, WIDTH, last completed word.
- valid, output, 1, dataOut holds an unread word.
- overrun, output, 1, sticky: a completed word overwrote an unread word.
- bitCnt, output, CW, number of bits of the current partial word received so far.

Behaviour:
- Reset (reset_L=0, asynchronous): shreg=0, bitCnt=0, dataOut=0, valid=0, overrun=0. Takes effect immediately and overrides everything, including mid-word. After release, reception restarts from bit 0.
- Priority on each rising edge: sync > shift.
- sync=1: bitCnt<=0 and shreg<=0. Any `shift` in the same cycle is ignored. dataOut, valid and overrun are unaffected.
- shift=1, sync=0, bitCnt<WIDTH-1: shift `sin` into shreg, then bitCnt<=bitCnt+1.
  - MSB_FIRST=1: shreg<={shreg[WIDTH-2:0],sin}.
  - MSB_FIRST=0: shreg<={sin,shreg[WIDTH-1:1]}.
- shift=1, sync=0, bitCnt==WIDTH-1 (word complete):
  - dataOut<=the assembled word including the current `sin`.
  - valid<=1, bitCnt<=0 (wrap).
  - Latency: dataOut and valid are visible immediately after the edge that samples the last bit.
- shift=0, sync=0: shreg and bitCnt hold. Gaps of any length between bits are legal.
- Handshake:
  - rd=1 while valid=1 clears valid on the next edge; dataOut holds its value.
  - rd while valid=0 has no effect.
- Simultaneous completion and rd: valid stays 1, dataOut takes the new word, no overrun.
- Completion while valid=1 and rd=0: dataOut is overwritten (newest wins), valid stays 1, overrun<=1.
- overrun stays 1 until clrOvr=1 or reset. If clrOvr and a new overrun occur in the same cycle, set wins (overrun stays 1).
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package `shift_reg_pkg`: default WIDTH constant and a MSB_FIRST/LSB_FIRST localparam pair, shared with the transmitter and both testers.
- One natural sub-module, `shift_reg_rx_cnt`: a modulo-WIDTH bit counter with sync clear and a wrap pulse. The datapath and handshake stay in the top module.
- Testbench structure: dut + `shift_reg_rx_tester`, plus a back-to-back variant connecting transmitter `sout` to receiver `sin`.

Test Plan:
1. Reset, then eight shift cycles of 0xA5 MSB-first (1,0,1,0,0,1,0,1) -> after the 8th edge dataOut=0xA5, valid=1, bitCnt=0, overrun=0; rd one cycle -> valid=0, dataOut still 0xA5.
2. Send 0x3C then 0xC3 with no rd -> after the second word dataOut=0xC3, valid=1, overrun=1; clrOvr -> overrun=0, valid still 1.
3. Hold valid from 0x11; assert rd on the exact edge completing 0x22 -> dataOut=0x22, valid=1, overrun=0.
4. Send 3 bits (1,1,1), pulse sync together with shift, then send 0x0F -> dataOut=0x0F and the partial bits are discarded; the shift in the sync cycle is not counted.
5. Send 5 bits with shift low for 4 cycles between bits 2 and 3, then assert reset_L=0 mid-word asynchronously -> all outputs 0 immediately; a following full 0x5A receives correctly.
6. MSB_FIRST=0: shift bits 1,0,0,0,0,0,0,0 -> dataOut=0x01. Back-to-back with the transmitter: carga 0x96 then 8 shifts -> receiver dataOut=0x96, valid=1.
